// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: preamble + SFD, optional zero pad to MIN_FRAME_LEN (macro ETH_TX_PAD_EN), CRC-32 FCS, inter-frame gap.
// Latency: preamble starts the clock after leaving IDLE; 8 bytes of preamble/SFD precede the first data byte.
// Backpressure: one output register that advances when empty or mac_tx_ready_in; input ready only in DATA and only on advance.
module eth_tx_framer #(
`ifdef ETH_TX_PAD_EN
    parameter int MIN_FRAME_LEN = 60,
`endif
    parameter int IFG_CYCLES    = 12,
    parameter int PREAMBLE_LEN  = 7
) (
    input  logic       logic_clk,
    input  logic       logic_rst,
    input  logic [7:0] trans_tnet_data_in,
    input  logic       trans_tnet_valid_in,
    output logic       trans_tnet_ready_out,
    input  logic       trans_tnet_last_in,
    output logic [7:0] mac_tx_data_out,
    output logic       mac_tx_valid_out,
    input  logic       mac_tx_ready_in,
    output logic       mac_tx_last_out,
    output logic       mac_tx_underrun_out
);
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, SFD, DATA, FCS, IFG
`ifdef ETH_TX_PAD_EN
        , PAD
`endif
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] crc, crc_nxt, fcs_word;
    logic [10:0] byte_cnt;
    logic [7:0]  pre_cnt, ifg_cnt;
    logic [1:0]  fcs_cnt;
    logic        adv, ld_en, ld_last, crc_en, cnt_inc, frm_clr;
    logic        pre_inc, fcs_inc, ifg_inc, ifg_clr, underrun_nxt;
    logic [7:0]  ld_dat;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        return r;
    endfunction

    assign adv      = !mac_tx_valid_out || mac_tx_ready_in;
    assign fcs_word = ~crc;
    assign crc_nxt  = crc_step(crc, ld_dat);

    always_ff @(posedge logic_clk) begin
        if (logic_rst) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt            = state;
        ld_en                = 1'b0;
        ld_dat               = 8'h00;
        ld_last              = 1'b0;
        crc_en               = 1'b0;
        cnt_inc              = 1'b0;
        frm_clr              = 1'b0;
        pre_inc              = 1'b0;
        fcs_inc              = 1'b0;
        ifg_inc              = 1'b0;
        ifg_clr              = 1'b0;
        underrun_nxt         = 1'b0;
        trans_tnet_ready_out = 1'b0;
        case (state)
            IDLE: begin
                if (trans_tnet_valid_in) begin
                    frm_clr   = 1'b1;
                    state_nxt = PREAMBLE;
                end
            end
            PREAMBLE: begin
                if (adv) begin
                    ld_en   = 1'b1;
                    ld_dat  = 8'h55;
                    pre_inc = 1'b1;
                    if (pre_cnt == 8'(PREAMBLE_LEN - 1)) state_nxt = SFD;
                end
            end
            SFD: begin
                if (adv) begin
                    ld_en     = 1'b1;
                    ld_dat    = 8'hD5;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                trans_tnet_ready_out = adv;
                if (adv && trans_tnet_valid_in) begin
                    ld_en   = 1'b1;
                    ld_dat  = trans_tnet_data_in;
                    crc_en  = 1'b1;
                    cnt_inc = 1'b1;
                    if (trans_tnet_last_in) begin
`ifdef ETH_TX_PAD_EN
                        if ({21'd0, byte_cnt} + 32'd1 < 32'(MIN_FRAME_LEN)) state_nxt = PAD;
                        else                                               state_nxt = FCS;
`else
                        state_nxt = FCS;
`endif
                    end
                end else if (adv) begin
                    underrun_nxt = 1'b1;
                end
            end
`ifdef ETH_TX_PAD_EN
            PAD: begin
                if (adv) begin
                    ld_en   = 1'b1;
                    crc_en  = 1'b1;
                    cnt_inc = 1'b1;
                    if ({21'd0, byte_cnt} + 32'd1 >= 32'(MIN_FRAME_LEN)) state_nxt = FCS;
                end
            end
`endif
            FCS: begin
                if (adv) begin
                    ld_en   = 1'b1;
                    ld_dat  = fcs_word[{fcs_cnt, 3'b000} +: 8];
                    fcs_inc = 1'b1;
                    if (fcs_cnt == 2'd3) begin
                        ld_last   = 1'b1;
                        state_nxt = IFG;
                    end
                end
            end
            IFG: begin
                // IDLE and the first PREAMBLE cycle supply the last two idle cycles of the gap.
                if (!mac_tx_valid_out) begin
                    ifg_inc = 1'b1;
                    if (ifg_cnt == 8'(IFG_CYCLES - 3)) begin
                        ifg_clr   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge logic_clk) begin
        if (logic_rst) begin
            mac_tx_data_out     <= 8'h00;
            mac_tx_valid_out    <= 1'b0;
            mac_tx_last_out     <= 1'b0;
            mac_tx_underrun_out <= 1'b0;
            crc                 <= 32'hFFFF_FFFF;
            byte_cnt            <= 11'd0;
            pre_cnt             <= 8'd0;
            fcs_cnt             <= 2'd0;
            ifg_cnt             <= 8'd0;
        end else begin
            mac_tx_underrun_out <= underrun_nxt;
            if (adv) begin
                mac_tx_valid_out <= ld_en;
                mac_tx_data_out  <= ld_dat;
                mac_tx_last_out  <= ld_last;
            end
            if (frm_clr) begin
                crc      <= 32'hFFFF_FFFF;
                byte_cnt <= 11'd0;
                pre_cnt  <= 8'd0;
                fcs_cnt  <= 2'd0;
            end else begin
                if (crc_en)                        crc      <= crc_nxt;
                if (cnt_inc && byte_cnt != 11'h7FF) byte_cnt <= byte_cnt + 11'd1;
                if (pre_inc)                       pre_cnt  <= pre_cnt + 8'd1;
                if (fcs_inc)                       fcs_cnt  <= fcs_cnt + 2'd1;
            end
            if (ifg_inc) ifg_cnt <= ifg_clr ? 8'd0 : ifg_cnt + 8'd1;
        end
    end
endmodule
